// File: rtl/ws2812_pkg.sv
// ---------------------------------------------------------------------------
// ws2812_pkg
// Shared definitions for the WS2812 receiver:
//   - rx_state_e   : decoder FSM states
//   - T_*_10M      : default pulse timing constants, in cycles of a 10 MHz clk
//   - PIXEL_BITS   : bits per pixel on the wire ({G,R,B}, MSB first)
// ---------------------------------------------------------------------------
package ws2812_pkg;

    typedef enum logic [1:0] {
        RESYNC = 2'd0,  // waiting for a full latch gap before trusting the line
        ARMED  = 2'd1,  // line idle low, aligned to a bit boundary
        HIGH   = 2'd2,  // measuring a high pulse
        LOW    = 2'd3   // between bits, watching for the latch gap
    } rx_state_e;

    localparam int unsigned T_THRESH_10M = 5;    // >= this many high cycles decodes as 1
    localparam int unsigned T_HMAX_10M   = 20;   // high pulse this long is invalid
    localparam int unsigned T_RESET_10M  = 500;  // low cycles forming a latch gap

    localparam int unsigned PIXEL_BITS = 24;

endpackage

// File: rtl/ws2812_rx_sync.sv
// ---------------------------------------------------------------------------
// ws2812_rx_sync
// Two-flop synchronizer for the asynchronous pad input plus a registered
// previous value for edge detection.
//   clk      : system clock
//   reset_n  : synchronous active-low reset, clears all three flops
//   din_i    : asynchronous pad data
//   din_s_o  : synchronized level
//   rise_o   : din_s_o went 0->1 this cycle
//   fall_o   : din_s_o went 1->0 this cycle
// ---------------------------------------------------------------------------
module ws2812_rx_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic din_i,
    output logic din_s_o,
    output logic rise_o,
    output logic fall_o
);

    logic [1:0] sync_q;
    logic       prev_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_q <= 2'b00;
            prev_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so each flop takes its neighbour's pre-edge
            // value; blocking would collapse the chain into a single stage.
            sync_q <= {sync_q[0], din_i};
            prev_q <= sync_q[1];
        end
    end

    assign din_s_o = sync_q[1];
    assign rise_o  = sync_q[1] & ~prev_q;
    assign fall_o  = ~sync_q[1] & prev_q;

endmodule

// File: rtl/ws2812_rx.sv
// ---------------------------------------------------------------------------
// ws2812_rx
// WS2812 single-wire LED stream receiver. Classifies each high pulse as a
// 0 or 1 by its length, assembles 24-bit pixels, reports each pixel with its
// index within the frame, and flags end-of-frame on the latch gap.
//
// Ports:
//   clk         : system clock (timing defaults assume 10 MHz)
//   reset_n     : synchronous active-low reset
//   din         : asynchronous WS2812 data from the pad
//   rgb_data    : last pixel, wire order {G,R,B}, MSB received first
//   led_num     : index of rgb_data within the current frame
//   valid       : 1-cycle strobe, rgb_data/led_num updated
//   frame_done  : 1-cycle strobe, latch gap after at least one full pixel
//   err         : 1-cycle strobe, protocol error
//   frame_count : (WS2812_RX_STATS_EN only) saturating frame_done count
//   err_count   : (WS2812_RX_STATS_EN only) saturating err count
//
// Optional feature macro: WS2812_RX_STATS_EN
// ---------------------------------------------------------------------------
module ws2812_rx
    import ws2812_pkg::*;
#(
    parameter int unsigned T_THRESH = T_THRESH_10M,
    parameter int unsigned T_HMAX   = T_HMAX_10M,
    parameter int unsigned T_RESET  = T_RESET_10M,
    parameter int unsigned MAX_LEDS = 256,
    parameter int unsigned CNT_W    = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        din,
    output logic [23:0] rgb_data,
    output logic [7:0]  led_num,
    output logic        valid,
    output logic        frame_done,
    output logic        err
`ifdef WS2812_RX_STATS_EN
    ,
    output logic [15:0] frame_count,
    output logic [7:0]  err_count
`endif
);

    localparam int unsigned PIX_W = $clog2(MAX_LEDS + 1);
    localparam int unsigned BIT_W = $clog2(PIXEL_BITS + 1);

    localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(T_THRESH);
    localparam logic [CNT_W-1:0] HMAX_C   = CNT_W'(T_HMAX);
    localparam logic [CNT_W-1:0] RESET_C  = CNT_W'(T_RESET);
    localparam logic [PIX_W-1:0] MAX_C    = PIX_W'(MAX_LEDS);
    localparam logic [BIT_W-1:0] FULL_C   = BIT_W'(PIXEL_BITS);

    // Timing counters stick at all-ones rather than wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    logic din_s, rise, fall;

    ws2812_rx_sync u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .din_i   (din),
        .din_s_o (din_s),
        .rise_o  (rise),
        .fall_o  (fall)
    );

    rx_state_e             state_q, state_d;
    logic [CNT_W-1:0]      hcnt_q, hcnt_d;
    logic [CNT_W-1:0]      lcnt_q, lcnt_d;
    logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [PIX_W-1:0]      pix_cnt_q, pix_cnt_d;
    logic [PIXEL_BITS-1:0] shreg_q, shreg_d;
    logic [23:0]           rgb_q, rgb_d;
    logic [7:0]            led_q, led_d;
    logic                  valid_q, valid_d;
    logic                  frame_done_q, frame_done_d;
    logic                  err_q, err_d;

    logic [CNT_W-1:0] hcnt_inc, lcnt_inc;
    assign hcnt_inc = sat_inc(hcnt_q);
    assign lcnt_inc = sat_inc(lcnt_q);

    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path
        // through the block can leave a value unassigned and infer a latch.
        state_d      = state_q;
        hcnt_d       = hcnt_q;
        lcnt_d       = lcnt_q;
        bit_cnt_d    = bit_cnt_q;
        pix_cnt_d    = pix_cnt_q;
        shreg_d      = shreg_q;
        rgb_d        = rgb_q;
        led_d        = led_q;
        valid_d      = 1'b0;
        frame_done_d = 1'b0;
        err_d        = 1'b0;

        // The 24th bit landed last cycle: publish the pixel. We are always in
        // LOW here (the bit was just closed by a falling edge), and LOW never
        // touches bit_cnt unless a latch gap completes, which cannot happen
        // one cycle after a fall.
        if (bit_cnt_q == FULL_C) begin
            bit_cnt_d = '0;
            if (pix_cnt_q < MAX_C) begin
                rgb_d     = shreg_q;
                led_d     = 8'(pix_cnt_q);
                valid_d   = 1'b1;
                pix_cnt_d = pix_cnt_q + 1'b1;
            end
        end

        unique case (state_q)
            RESYNC: begin
                if (din_s) begin
                    lcnt_d = '0;
                end else begin
                    lcnt_d = lcnt_inc;
                    if (lcnt_inc >= RESET_C) begin
                        state_d   = ARMED;
                        bit_cnt_d = '0;
                        pix_cnt_d = '0;
                    end
                end
            end

            ARMED: begin
                if (rise) begin
                    state_d = HIGH;
                    hcnt_d  = CNT_W'(1);
                end
            end

            HIGH: begin
                // A falling edge is checked first, so a pulse ending on the
                // very cycle it would hit T_HMAX still counts as a bit.
                if (fall) begin
                    shreg_d   = {shreg_q[PIXEL_BITS-2:0], (hcnt_q >= THRESH_C)};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    state_d   = LOW;
                    lcnt_d    = CNT_W'(1);
                end else begin
                    hcnt_d = hcnt_inc;
                    if (hcnt_inc >= HMAX_C) begin
                        err_d     = 1'b1;
                        bit_cnt_d = '0;
                        lcnt_d    = '0;
                        state_d   = RESYNC;
                    end
                end
            end

            LOW: begin
                if (rise) begin
                    state_d = HIGH;
                    hcnt_d  = CNT_W'(1);
                end else begin
                    lcnt_d = lcnt_inc;
                    if (lcnt_inc >= RESET_C) begin
                        if (bit_cnt_q != '0) begin
                            err_d = 1'b1;
                        end else if (pix_cnt_q != '0) begin
                            frame_done_d = 1'b1;
                        end
                        bit_cnt_d = '0;
                        pix_cnt_d = '0;
                        state_d   = ARMED;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= RESYNC;
            hcnt_q       <= '0;
            lcnt_q       <= '0;
            bit_cnt_q    <= '0;
            pix_cnt_q    <= '0;
            shreg_q      <= '0;
            rgb_q        <= '0;
            led_q        <= '0;
            valid_q      <= 1'b0;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            hcnt_q       <= hcnt_d;
            lcnt_q       <= lcnt_d;
            bit_cnt_q    <= bit_cnt_d;
            pix_cnt_q    <= pix_cnt_d;
            shreg_q      <= shreg_d;
            rgb_q        <= rgb_d;
            led_q        <= led_d;
            valid_q      <= valid_d;
            frame_done_q <= frame_done_d;
            err_q        <= err_d;
        end
    end

    assign rgb_data   = rgb_q;
    assign led_num    = led_q;
    assign valid      = valid_q;
    assign frame_done = frame_done_q;
    assign err        = err_q;

`ifdef WS2812_RX_STATS_EN
    logic [15:0] frame_count_q;
    logic [7:0]  err_count_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            frame_count_q <= '0;
            err_count_q   <= '0;
        end else begin
            if (frame_done_q && (frame_count_q != '1)) frame_count_q <= frame_count_q + 1'b1;
            if (err_q && (err_count_q != '1))          err_count_q   <= err_count_q + 1'b1;
        end
    end

    assign frame_count = frame_count_q;
    assign err_count   = err_count_q;
`endif

endmodule

// File: tb/tb_ws2812_rx.sv
// ---------------------------------------------------------------------------
// tb_ws2812_rx
// Random and directed WS2812 streams. A protocol-level model (bit lists,
// pixel index, "have we seen a latch gap" flag) predicts each strobe and
// pushes it into a queue; a monitor pops and compares whenever the DUT
// raises valid, frame_done or err.
// ---------------------------------------------------------------------------
module tb_ws2812_rx;

    localparam int T_THRESH = 5;
    localparam int T_HMAX   = 20;
    localparam int T_RESET  = 500;
    localparam int MAX_LEDS = 256;

    localparam logic [2:0] K_PIX   = 3'b100;  // {valid, frame_done, err}
    localparam logic [2:0] K_FRAME = 3'b010;
    localparam logic [2:0] K_ERR   = 3'b001;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        din = 1'b0;
    logic [23:0] rgb_data;
    logic [7:0]  led_num;
    logic        valid, frame_done, err;
`ifdef WS2812_RX_STATS_EN
    logic [15:0] frame_count;
    logic [7:0]  err_count;
`endif

    ws2812_rx dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .din        (din),
        .rgb_data   (rgb_data),
        .led_num    (led_num),
        .valid      (valid),
        .frame_done (frame_done),
        .err        (err)
`ifdef WS2812_RX_STATS_EN
        ,
        .frame_count(frame_count),
        .err_count  (err_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  kind;
        logic [23:0] rgb;
        logic [7:0]  led;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    // Protocol-level reference state.
    bit          synced;
    int          nbits;
    logic [23:0] acc;
    int          pix;
    int          exp_frames;
    int          exp_errs;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void push(input logic [2:0] k, input logic [23:0] rgb, input logic [7:0] led);
        ev_t e;
        e.kind = k;
        e.rgb  = rgb;
        e.led  = led;
        exp_q.push_back(e);
        if (k == K_FRAME) exp_frames++;
        if (k == K_ERR)   exp_errs++;
    endfunction

    function automatic void model_reset();
        synced     = 1'b0;
        nbits      = 0;
        acc        = '0;
        pix        = 0;
        exp_frames = 0;
        exp_errs   = 0;
    endfunction

    // One high pulse of h cycles followed by a short low.
    function automatic void model_bit(input int h);
        if (h >= T_HMAX) begin
            if (synced) push(K_ERR, '0, '0);
            synced = 1'b0;
            nbits  = 0;
            return;
        end
        if (!synced) return;
        acc   = {acc[22:0], (h >= T_THRESH) ? 1'b1 : 1'b0};
        nbits = nbits + 1;
        if (nbits == 24) begin
            nbits = 0;
            if (pix < MAX_LEDS) begin
                push(K_PIX, acc, 8'(pix));
                pix = pix + 1;
            end
        end
    endfunction

    // A low stretch of at least T_RESET cycles.
    function automatic void model_gap();
        if (synced) begin
            if (nbits != 0)   push(K_ERR, '0, '0);
            else if (pix > 0) push(K_FRAME, '0, '0);
        end
        synced = 1'b1;
        nbits  = 0;
        pix    = 0;
    endfunction

    task automatic send_bit(input int h, input int l);
        model_bit(h);
        din = 1'b1;
        repeat (h) @(negedge clk);
        din = 1'b0;
        repeat (l) @(negedge clk);
    endtask

    // mode 0: 3/9 and 7/5; 1: 4 vs 5 high; 2: random legal; 3: short
    task automatic send_pixel(input logic [23:0] px, input int mode);
        for (int i = 23; i >= 0; i--) begin
            bit b;
            int h, l;
            b = px[i];
            case (mode)
                0:       begin h = b ? 7 : 3; l = b ? 5 : 9; end
                1:       begin h = b ? 5 : 4; l = 6; end
                2:       begin h = b ? int'($urandom_range(5, 19)) : int'($urandom_range(1, 4));
                               l = int'($urandom_range(1, 12)); end
                default: begin h = b ? 5 : 2; l = 2; end
            endcase
            send_bit(h, l);
        end
    endtask

    task automatic send_gap(input int n);
        model_gap();
        din = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
        check(name, exp_q.size(), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        model_reset();
        check("rst_valid", valid, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_err", err, 0);
        check("rst_rgb_data", rgb_data, 0);
        check("rst_led_num", led_num, 0);
        reset_n = 1'b1;
    endtask

    // Monitor: one pop per strobe cycle.
    always @(negedge clk) begin
        ev_t e;
        if (reset_n && (valid || frame_done || err)) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe got %b expected none rgb %0h led %0d at %0t",
                         {valid, frame_done, err}, rgb_data, led_num, $time);
            end else begin
                e = exp_q.pop_front();
                check("strobe_kind", 32'({valid, frame_done, err}), 32'(e.kind));
                if (e.kind == K_PIX) begin
                    check("rgb_data", rgb_data, e.rgb);
                    check("led_num", led_num, e.led);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout pending %0d expected none", exp_q.size());
        $fatal(1, "timeout");
    end

    logic [23:0] px, last_px;

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        do_reset();

        // Pixel straight after reset without a gap: must be ignored.
        send_pixel(24'hA5C33C, 0);
        drain("nogap_drain");

        // Basic two-pixel frame.
        send_gap(500);
        send_pixel(24'hFF0000, 0);
        send_pixel(24'h00FF00, 0);
        send_gap(500);
        drain("frame2_drain");
        check("frame2_rgb_hold", rgb_data, 24'h00FF00);
        check("frame2_led_hold", led_num, 8'd1);

        // Partial pixel then gap: err, then a clean pixel restarts at 0.
        for (int i = 0; i < 12; i++) send_bit(($urandom_range(0, 1) != 0) ? 7 : 3, 6);
        send_gap(500);
        send_pixel(24'($urandom), 0);
        send_gap(500);
        drain("partial_drain");

        // Stuck-high pulse mid-pixel: err, ignore until gap.
        send_pixel(24'($urandom), 0);
        for (int i = 0; i < 8; i++) send_bit(7, 5);
        send_bit(25, 10);
        send_pixel(24'($urandom), 0);
        send_gap(520);
        send_pixel(24'($urandom), 0);
        send_gap(500);
        drain("stuck_drain");

        // Threshold boundaries: 4 high -> 0, 5 high -> 1; 19 high still a bit.
        send_pixel(24'h800001, 1);
        drain("thresh_drain");
        check("thresh_rgb", rgb_data, 24'h800001);
        for (int i = 0; i < 24; i++) send_bit(19, 3);
        send_bit(20, 5);
        send_gap(520);
        drain("hmax_drain");
        check("hmax_rgb", rgb_data, 24'hFFFFFF);

        // Random frames, some with a truncated tail.
        for (int f = 0; f < 5; f++) begin
            int np;
            np = int'($urandom_range(1, 4));
            for (int p = 0; p < np; p++) send_pixel(24'($urandom), 2);
            if ($urandom_range(0, 3) == 0) begin
                int nb;
                nb = int'($urandom_range(1, 23));
                for (int i = 0; i < nb; i++) send_bit(int'($urandom_range(1, 19)), int'($urandom_range(1, 12)));
            end
            send_gap(int'($urandom_range(500, 560)));
        end
        drain("random_drain");

        // Reset mid-pixel.
        send_pixel(24'($urandom) | 24'h000100, 0);
        for (int i = 0; i < 10; i++) send_bit(7, 5);
        drain("premid_drain");
        do_reset();
        for (int i = 0; i < 14; i++) send_bit(7, 5);
        repeat (20) @(negedge clk);
        drain("midrst_drain");
        send_gap(500);
        send_pixel(24'($urandom), 0);
        send_gap(500);
        drain("postrst_drain");

        // Over-long frame: pixels past MAX_LEDS dropped, outputs hold.
        for (int p = 0; p < MAX_LEDS + 2; p++) begin
            px = 24'($urandom);
            if (p == MAX_LEDS - 1) last_px = px;
            send_pixel(px, 3);
        end
        send_gap(500);
        drain("sat_drain");
        check("sat_rgb_hold", rgb_data, last_px);
        check("sat_led_hold", led_num, 8'd255);

`ifdef WS2812_RX_STATS_EN
        check("frame_count", frame_count, 32'(exp_frames));
        check("err_count", err_count, 32'(exp_errs));
        do_reset();
        check("frame_count_rst", frame_count, 0);
        check("err_count_rst", err_count, 0);
`endif

        repeat (20) @(negedge clk);
        drain("final_drain");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ws2812_rx.md
Name: ws2812_rx

Overview:
- Receiver for the WS2812 single-wire LED protocol, the opposite end of the harness's ws2812 transmitter project.
- Samples a pad input, classifies each high pulse as a 0 or 1 bit, and assembles 24-bit pixels.
- Emits each pixel with its index within the frame and flags end-of-frame on the latch (reset) gap.
- Used as a loopback checker for the transmitter project and as a standalone LED-stream sniffer harness project.

Parameters:
- T_THRESH, 5: high-pulse cycles at or above which a bit decodes as 1; below decodes as 0. Default assumes 10 MHz clk.
- T_HMAX, 20: high-pulse cycles at which the pulse is declared invalid.
- T_RESET, 500: low cycles that constitute a latch gap.
- MAX_LEDS, 256: pixels accepted per frame; later pixels are dropped.
- CNT_W, 10: width of the timing counters; must satisfy 2^CNT_W > T_RESET.

Ports:
- clk  input  1  single system clock.
- reset_n  input  1  synchronous, active-low reset.
- din  input  1  asynchronous WS2812 data from the pad.
- rgb_data  output  24  last pixel in wire order {G[7:0],R[7:0],B[7:0]}, MSB first received.
- led_num  output  8  index of the rgb_data pixel within the current frame.
- valid  output  1  one-cycle strobe: rgb_data/led_num updated.
- frame_done  output  1  one-cycle strobe: latch gap seen after at least one complete pixel.
- err  output  1  one-cycle strobe: protocol error.

Behaviour:
- Reset (reset_n low at a clk edge): all outputs 0, synchronizer flops 0, state RESYNC, all counters 0.
- Input path: 2-flop synchronizer produces din_s, plus a registered previous value for edge detection. Pad-to-edge-detect latency is 3 clk.
- FSM:
  - RESYNC: lcnt counts while din_s=0 and clears on din_s=1. When lcnt reaches T_RESET → ARMED, with bit_cnt=0 and pix_cnt=0.
  - ARMED: rising edge → HIGH, hcnt=1.
  - HIGH: hcnt increments each cycle.
    - Falling edge: bit=(hcnt>=T_THRESH); shreg={shreg[22:0],bit}; bit_cnt++; → LOW, lcnt=1.
    - hcnt reaches T_HMAX: err pulse, drop partial pixel → RESYNC.
  - LOW: rising edge → HIGH, hcnt=1. When lcnt reaches T_RESET:
    - if bit_cnt≠0: err pulse, partial pixel discarded;
    - else if pix_cnt>0: frame_done pulse;
    - in all cases pix_cnt=0, bit_cnt=0 → ARMED.
- Pixel completion: when the 24th bit is shifted in, on the next clk edge:
  - rgb_data<=shreg, led_num<=pix_cnt, valid=1 for one cycle, bit_cnt=0, pix_cnt++.
  - If pix_cnt≥MAX_LEDS: no valid, rgb_data/led_num hold, pix_cnt saturates; no error.
- Timing counters saturate; they never wrap.
- Edge case: a falling edge in the same cycle hcnt would reach T_HMAX counts as a valid bit (edge wins).
- rgb_data and led_num hold their values between strobes.
- valid and frame_done are never high in the same cycle, because frame_done requires ≥T_RESET low cycles after the last bit.
- Reset asserted mid-pixel: partial data is lost, no strobes are emitted, and the block re-enters RESYNC (must see a full latch gap before decoding).

Optional Feature:
- Macro WS2812_RX_STATS_EN.
- When defined, adds outputs frame_count[15:0] (increments on frame_done) and err_count[7:0] (increments on err). Both saturate and are cleared by reset_n.
- When undefined, these ports and their counters are absent and behaviour is otherwise identical.

Decomposition:
- Package ws2812_pkg holds:
  - the FSM state enum (RESYNC, ARMED, HIGH, LOW);
  - default timing constants T_THRESH/T_HMAX/T_RESET at 10 MHz;
  - PIXEL_BITS=24.
- One sub-module, ws2812_rx_sync: 2-flop synchronizer with rise/fall edge outputs.

Test Plan (10 MHz clk, default parameters; bit 0 = 3 high + 9 low cycles, bit 1 = 7 high + 5 low cycles):
- Hold din low 500 cycles, send 0xFF0000 then 0x00FF00, then low 500 cycles → valid twice: rgb_data=0xFF0000/led_num=0, then 0x00FF00/led_num=1; then one frame_done; err never high.
- Send 12 bits, then low 500 cycles → err pulses once, no valid, no frame_done; next full pixel decodes with led_num=0.
- Mid-stream, hold din high for 25 cycles → err at the 20th high cycle; FSM in RESYNC; pixels ignored until a 500-cycle low gap.
- Boundary pulses: 4 high cycles → 0; 5 high cycles → 1; send 0x800001 with that encoding → rgb_data=0x800001.
- After reset, send a pixel with no preceding gap → no valid. Pull reset_n low mid-pixel for 1 cycle → outputs 0; no strobes until a gap and a fresh pixel.
- With WS2812_RX_STATS_EN: 3 frames plus 2 error events → frame_count=3, err_count=2; reset_n clears both.
